// File: rtl/data_delay_line.sv
// ============================================================================
// data_delay_line : multi-channel runtime-programmable delay line with valid
//                   tracking, clock-enable stall and synchronous flush
// Revision        : 1.0
// ============================================================================
`default_nettype none

module data_delay_line #(
  parameter int MAX_LATENCY = 8,
  parameter int IWIDTH      = 8,
  parameter int NCH         = 1,
  parameter int DEFAULT_LAT = 1,
  parameter int LAT_W       = $clog2(MAX_LATENCY + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ce,
  input  logic                  flush,
  input  logic [LAT_W-1:0]      lat_sel,
  input  logic                  ivalid,
  input  logic [NCH*IWIDTH-1:0] idata,
  output logic                  ovalid,
  output logic [NCH*IWIDTH-1:0] odata,
  output logic                  busy,
  output logic                  lat_err
);

  localparam int c_DW = NCH * IWIDTH;

  logic [c_DW-1:0]        r_data [1:MAX_LATENCY];
  logic [MAX_LATENCY:1]   r_vld;
  logic [LAT_W-1:0]       r_lat_q;
  logic                   r_lat_err;

  logic                   w_over;
  logic [LAT_W-1:0]       w_lat_eff;
  logic                   w_lat_chg;
  logic [c_DW-1:0]        w_odata;
  logic                   w_ovalid;
  logic                   w_busy;

  assign w_over    = (lat_sel > LAT_W'(MAX_LATENCY));
  assign w_lat_eff = w_over ? LAT_W'(MAX_LATENCY) : lat_sel;
  assign w_lat_chg = (w_lat_eff != r_lat_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= MAX_LATENCY; k++) begin
        r_data[k] <= '0;
      end
      r_vld     <= '0;
      r_lat_q   <= LAT_W'(DEFAULT_LAT);
      r_lat_err <= 1'b0;
    end else begin
      if (w_lat_chg) begin
        r_lat_q <= w_lat_eff;
      end

      if (flush) begin
        r_lat_err <= 1'b0;
      end else if (w_over) begin
        r_lat_err <= 1'b1;
      end

      // A latency change invalidates everything in flight, including this cycle's input
      if (flush || w_lat_chg) begin
        r_vld <= '0;
      end else if (ce) begin
        r_vld[1] <= ivalid;
        for (int k = 2; k <= MAX_LATENCY; k++) begin
          r_vld[k] <= r_vld[k-1];
        end
      end

      // Flush dominates ce: data stays put so the stages are frozen for that cycle
      if (ce && !flush) begin
        r_data[1] <= idata;
        for (int k = 2; k <= MAX_LATENCY; k++) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  always_comb begin
    w_odata  = idata;
    w_ovalid = ce & ivalid;
    w_busy   = 1'b0;
    for (int k = 1; k <= MAX_LATENCY; k++) begin
      if (r_lat_q == LAT_W'(k)) begin
        w_odata  = r_data[k];
        w_ovalid = ce & r_vld[k];
      end
      if (LAT_W'(k) <= r_lat_q) begin
        w_busy = w_busy | r_vld[k];
      end
    end
  end

  assign odata   = w_odata;
  assign ovalid  = w_ovalid;
  assign busy    = w_busy;
  assign lat_err = r_lat_err;

endmodule

`default_nettype wire
